// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared types and widths for the viterbi_ctrl arbiter
package viterbi_pkg;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;
  localparam logic VIT1_CODE = 1'b0;
  localparam logic VIT2_CODE = 1'b1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, COMPLETE} arb_state_t;
endpackage

// File: rtl/viterbi_rr_pick.sv
// viterbi_rr_pick: rotate-priority encoder; req_i/ptr_i in, valid_o/idx_o = first set bit at or after ptr_i (wrapping)
module viterbi_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);
  logic [IW-1:0] j;
  // scan from farthest to nearest so the nearest requester wins
  always_comb begin
    valid_o = |req_i;
    idx_o = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr_i) + k) % N);
      if (req_i[j]) idx_o = j;
    end
  end
endmodule

// File: rtl/viterbi_arbiter.sv
// viterbi_arbiter: round-robin share of one viterbi_ctrl among N_REQ requesters; req*/done/err/rdata host side, ctrl_* controller side, busy status
module viterbi_arbiter
  import viterbi_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                clk,
  input  logic                reset_all,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    req_write,
  input  logic [3*N_REQ-1:0]  req_addr,
  input  logic [8*N_REQ-1:0]  req_data,
  input  logic [N_REQ-1:0]    req_vit,
  output logic [N_REQ-1:0]    done,
  output logic                err,
  output logic [DATA_W-1:0]   rdata,
  output logic                busy,
  output logic                ctrl_start,
  output logic                ctrl_is_write,
  output logic                ctrl_vit_num,
  output logic [ADDR_W-1:0]   ctrl_addr,
  output logic [DATA_W-1:0]   ctrl_data,
  input  logic                ctrl_finish,
  input  logic [DATA_W-1:0]   ctrl_return_data
);
  localparam int IW = $clog2(N_REQ);
  localparam int WW = $clog2(TIMEOUT_CYC);
  arb_state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, gnt_q, gnt_d, pick_idx;
  logic pick_valid;
  logic [WW-1:0] wd_q, wd_d;
  logic err_q, err_d, cw_q, cw_d, cv_q, cv_d;
  logic [DATA_W-1:0] rdata_q, rdata_d, cd_q, cd_d;
  logic [ADDR_W-1:0] ca_q, ca_d;
  viterbi_rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req_i(req), .ptr_i(ptr_q), .valid_o(pick_valid), .idx_o(pick_idx)
  );
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    gnt_d = gnt_q;
    wd_d = wd_q;
    err_d = err_q;
    rdata_d = rdata_q;
    cw_d = cw_q;
    cv_d = cv_q;
    ca_d = ca_q;
    cd_d = cd_q;
    case (state_q)
      IDLE: if (pick_valid) begin
        gnt_d = pick_idx;
        cw_d = req_write[pick_idx];
        cv_d = req_vit[pick_idx];
        ca_d = req_addr[ADDR_W*pick_idx +: ADDR_W];
        cd_d = req_data[DATA_W*pick_idx +: DATA_W];
        state_d = ISSUE;
      end
      ISSUE: begin
        wd_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wd_d = wd_q + 1'b1;
        // finish wins over a timeout landing in the same cycle
        if (ctrl_finish) begin
          rdata_d = cw_q ? '0 : ctrl_return_data;
          err_d = 1'b0;
          state_d = COMPLETE;
        end else if (wd_q == WW'(TIMEOUT_CYC - 1)) begin
          rdata_d = '0;
          err_d = 1'b1;
          state_d = COMPLETE;
        end
      end
      COMPLETE: begin
        ptr_d = (gnt_q == IW'(N_REQ - 1)) ? '0 : gnt_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_all) begin
    if (!reset_all) begin
      state_q <= IDLE;
      ptr_q <= '0;
      gnt_q <= '0;
      wd_q <= '0;
      err_q <= 1'b0;
      rdata_q <= '0;
      cw_q <= 1'b0;
      cv_q <= VIT1_CODE;
      ca_q <= '0;
      cd_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      gnt_q <= gnt_d;
      wd_q <= wd_d;
      err_q <= err_d;
      rdata_q <= rdata_d;
      cw_q <= cw_d;
      cv_q <= cv_d;
      ca_q <= ca_d;
      cd_q <= cd_d;
    end
  end
  assign busy = state_q != IDLE;
  assign ctrl_start = state_q == ISSUE;
  assign done = (state_q == COMPLETE) ? N_REQ'(1) << gnt_q : '0;
  assign err = err_q;
  assign rdata = rdata_q;
  assign ctrl_is_write = cw_q;
  assign ctrl_vit_num = cv_q;
  assign ctrl_addr = ca_q;
  assign ctrl_data = cd_q;
endmodule

// File: doc/viterbi_arbiter.md
Name: viterbi_arbiter

Overview:
- Shares one `viterbi_ctrl` bus controller between N_REQ host requesters using round-robin arbitration.
- Latches the granted request, sequences the controller's start/finish handshake, and returns read data with a per-requester done pulse.
- A watchdog aborts a transaction if finish never arrives.
- Sits between host-side command sources and `viterbi_ctrl`. The arbiter's `ctrl_*` outputs drive the controller's in_addr, in_data, is_write, vit_num and start inputs.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYC, 15, maximum cycles spent in WAIT before abort (>= 6).

Ports:
- clk  input  1  single clock (one clock domain)
- reset_all  input  1  reset, asynchronous, active-low
- req  input  N_REQ  per-requester request; held high until done
- req_write  input  N_REQ  per-requester op: 1 = write, 0 = read
- req_addr  input  3*N_REQ  flattened; slice i = [3i+2:3i]
- req_data  input  8*N_REQ  flattened write data, slice i = [8i+7:8i]
- req_vit  input  N_REQ  target chip select, 0 = vit1, 1 = vit2
- done  output  N_REQ  one-cycle completion pulse, one-hot
- err  output  1  valid with done; 1 = timeout abort
- rdata  output  8  read result, valid while any done bit is high
- busy  output  1  high in any state except IDLE
- ctrl_start  output  1  start strobe to controller
- ctrl_is_write, ctrl_vit_num  output  1 each  latched op fields
- ctrl_addr  output  3  latched address
- ctrl_data  output  8  latched write data
- ctrl_finish  input  1  controller finish pulse
- ctrl_return_data  input  8  controller read register

Behaviour:
- Reset: all outputs 0, FSM in IDLE, round-robin pointer = 0, watchdog counter = 0. Reset asserted mid-transaction aborts immediately with no done pulse; requesters must re-request.
- States (registered, Moore outputs): IDLE, ISSUE, WAIT, COMPLETE.
- IDLE: if any req bit is high, grant the first requester at or after the pointer, scanning upward with wrap from N_REQ-1 to 0. Latch its write/addr/data/vit into the ctrl_* registers and its index into gnt_idx. Go to ISSUE. If no req is high, stay in IDLE.
- ISSUE: ctrl_start = 1 for exactly one cycle; clear watchdog; go to WAIT.
- WAIT: ctrl_start = 0; watchdog increments every cycle.
  - If ctrl_finish = 1: capture ctrl_return_data (reads) or 8'h00 (writes) into rdata; err <= 0; go to COMPLETE.
  - Else if watchdog == TIMEOUT_CYC-1: rdata <= 8'h00; err <= 1; go to COMPLETE.
  - ctrl_finish takes priority over timeout in the same cycle.
- COMPLETE: done[gnt_idx] = 1 for one cycle; pointer <= (gnt_idx+1) mod N_REQ; go to IDLE. ctrl_finish seen in ISSUE, IDLE or COMPLETE is ignored.
- ctrl_* fields stay constant from ISSUE through COMPLETE; the controller samples them combinationally.
- Requester rule: deassert req in the cycle after done. req still high in the IDLE cycle that follows is treated as a new request. Requester fields are ignored except in the IDLE grant cycle.
- Latency with `viterbi_ctrl`:
  - Write: ctrl_finish arrives 4 cycles after the ISSUE cycle; done asserts 5 cycles after ISSUE.
  - Read: ctrl_finish arrives 5 cycles after ISSUE; done asserts 6 cycles after ISSUE.
  - Grant is 1 cycle after req is seen in IDLE.
- No back-to-back issue: at least one IDLE cycle separates transactions, which matches the controller's finished-to-idle return.
- Simultaneous requests are resolved by the pointer only. A requester never waits more than N_REQ-1 other transactions.

Decomposition:
- Package `viterbi_pkg`: arb_state_t enum; VIT1_CODE = 1'b0, VIT2_CODE = 1'b1; ADDR_W = 3, DATA_W = 8.
- Sub-module `viterbi_rr_pick`: combinational rotate-priority encoder. Inputs: req vector and pointer. Outputs: valid and index.

Test Plan:
- Single write: requester 2 issues addr=5, data=8'hA7, vit=1 -> grant next cycle, then ctrl_start pulses once. ctrl_addr=5, ctrl_data=A7 and ctrl_vit_num=1 are held. done[2] asserts 5 cycles after ISSUE with err=0; pointer becomes 3.
- Single read: requester 0 reads addr=3 while the controller model returns 8'h3C -> done[0] with rdata=3C and err=0, 6 cycles after ISSUE.
- Contention: all 4 requesters high from reset -> service order 0,1,2,3. After requester 1 re-requests, order continues 0,1; no requester is skipped or serviced twice.
- Timeout: model never asserts finish -> done asserts after TIMEOUT_CYC WAIT cycles (default 15) with err=1 and rdata=00. The next request proceeds normally.
- Finish coincides with the timeout cycle -> err=0 and rdata captured.
- Reset mid-WAIT: reset_all pulled low -> all outputs 0 asynchronously, no done. After release, a pending req is granted with pointer 0.
